// File: rtl/neural_ch_packetizer.sv
// Channel sweeper/packetizer: latches one timestamped frame and streams one 64-bit packet per enabled channel.
// Optional NEURAL_PKT_DROP_CNT_EN compiles in the saturating dropped-frame counter.
module neural_ch_packetizer #(
    parameter int DATA_WIDTH   = 16,
    parameter int CH_ID_WIDTH  = 4,
    parameter int NUM_CHANNELS = 16
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               enable,
    input  logic [NUM_CHANNELS-1:0]            ch_mask,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] snap_data,
    input  logic                               snap_valid,
    output logic                               snap_ready,
    output logic [63:0]                        pkt_data,
    output logic                               pkt_valid,
    input  logic                               pkt_ready,
    output logic                               overrun,
    output logic [15:0]                        drop_count
);

    typedef enum logic {IDLE, SWEEP} state_t;
    typedef logic [CH_ID_WIDTH-1:0] ch_t;
    typedef logic [NUM_CHANNELS-1:0] mask_t;
    typedef logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] frame_t;

    state_t      state;
    logic [31:0] ts_cnt;
    logic [31:0] frame_ts;
    frame_t      frame_data;
    frame_t      snap_frame;
    // Enabled channels strictly above the one currently on pkt_data.
    mask_t       rem_mask;

    function automatic ch_t lowest(input mask_t m);
        ch_t c;
        c = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (m[i]) c = ch_t'(i);
        return c;
    endfunction

    function automatic logic [63:0] build(input logic [31:0] ts, input ch_t ch,
                                          input logic [DATA_WIDTH-1:0] s,
                                          input logic sof, input logic eof);
        logic [63:0] p;
        p = '0;
        p[63:32] = ts;
        p[31 -: CH_ID_WIDTH] = ch;
        p[31-CH_ID_WIDTH -: DATA_WIDTH] = s;
        p[1] = eof;
        p[0] = sof;
        return p;
    endfunction

    ch_t   first_ch, next_ch;
    mask_t first_rem, next_rem;
    logic  accept, drop;

    assign snap_frame = snap_data;
    assign first_ch   = lowest(ch_mask);
    assign first_rem  = ch_mask & (ch_mask - mask_t'(1));
    assign next_ch    = lowest(rem_mask);
    assign next_rem   = rem_mask & (rem_mask - mask_t'(1));
    assign accept     = (state == IDLE) && snap_valid && enable && (|ch_mask);
    assign drop       = (state == SWEEP) && snap_valid;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ts_cnt <= '0;
        else            ts_cnt <= ts_cnt + 32'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            frame_ts   <= '0;
            frame_data <= '0;
            rem_mask   <= '0;
            pkt_data   <= '0;
            pkt_valid  <= 1'b0;
            snap_ready <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            overrun <= drop;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SWEEP;
                        frame_ts   <= ts_cnt;
                        frame_data <= snap_frame;
                        rem_mask   <= first_rem;
                        pkt_data   <= build(ts_cnt, first_ch, snap_frame[first_ch], 1'b1, first_rem == '0);
                        pkt_valid  <= 1'b1;
                        snap_ready <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (pkt_ready) begin
                        if (rem_mask == '0) begin
                            state      <= IDLE;
                            pkt_data   <= '0;
                            pkt_valid  <= 1'b0;
                            snap_ready <= 1'b1;
                        end else begin
                            rem_mask <= next_rem;
                            pkt_data <= build(frame_ts, next_ch, frame_data[next_ch], 1'b0, next_rem == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NEURAL_PKT_DROP_CNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                          drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
`else
    assign drop_count = 16'h0000;
`endif

endmodule

// File: doc/neural_ch_packetizer.md
# neural_ch_packetizer

Single-clock channel sweeper and packetizer for the neural acquisition pipeline, sitting in the system domain between the parallel sample snapshot and the output CDC FIFO. It captures one frame of NUM_CHANNELS samples, timestamps it, and emits one 64-bit packet per enabled channel, in ascending channel order, over a valid/ready stream. It generalises the fixed 16-channel sweep with a per-channel enable mask, start/end-of-frame flags and overrun accounting.

## Interface
- DATA_WIDTH, 16, sample width; DATA_WIDTH + CH_ID_WIDTH <= 30
- CH_ID_WIDTH, 4, channel-ID field width
- NUM_CHANNELS, 16, channels per frame; 1 <= NUM_CHANNELS <= 2**CH_ID_WIDTH
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- enable  in  1  CSR enable bit; frames accepted only when 1
- ch_mask  in  NUM_CHANNELS  CSR channel enable mask; bit i = channel i
- snap_data  in  NUM_CHANNELS*DATA_WIDTH  flattened samples; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- snap_valid  in  1  one-cycle frame strobe
- snap_ready  out  1  high in IDLE
- pkt_data  out  64  packet
- pkt_valid  out  1  packet valid
- pkt_ready  in  1  downstream ready
- overrun  out  1  one-cycle pulse on a dropped frame
- drop_count  out  16  dropped-frame counter (see Configuration)

## Operation
- Free-running 32-bit ts_cnt increments every cycle from 0 after reset; wraps 0xFFFFFFFF -> 0.
- States: IDLE, SWEEP.
- IDLE: snap_valid && enable && (ch_mask != 0) -> latch snap_data, ch_mask, ts_cnt into frame registers; go SWEEP with cursor at the lowest set mask bit.
- IDLE: snap_valid with enable=0 or ch_mask=0 -> frame ignored, not counted as drop.
- SWEEP: pkt_valid=1; cursor is the current channel. On pkt_valid && pkt_ready, advance cursor to the next higher set bit of the latched mask; if none, go IDLE.
- Masked-out channels are skipped with zero cycles' penalty; cursor search is combinational priority-encode over latched mask above cursor.
- Packet layout: [63:32] latched timestamp; [31 -: CH_ID_WIDTH] channel ID; next DATA_WIDTH bits sample; [1] eof (last enabled channel); [0] sof (first enabled channel); all other bits 0. Default: CH [31:28], DATA [27:12], [11:2]=0.
- Single-enabled-channel frame: one packet with sof=1 and eof=1.
- snap_valid in SWEEP (including the final-handshake cycle): frame dropped, overrun pulses next cycle, drop_count increments if compiled in.
- enable or ch_mask changing during SWEEP: no effect on the current frame; the latched copy is used.

## Timing
- Reset values: pkt_valid=0, pkt_data=0, snap_ready=1, overrun=0, drop_count=0, ts_cnt=0, state IDLE.
- Accept at cycle N -> pkt_valid=1 with first packet at N+1; snap_ready=0 from N+1.
- With pkt_ready held 1: k enabled channels occupy cycles N+1..N+k; IDLE and snap_ready=1 at N+k+1; next frame acceptable at N+k+1.
- pkt_valid && !pkt_ready: pkt_data and pkt_valid held stable; no retraction.
- overrun asserted exactly one cycle, at the cycle after the dropped snap_valid.
- Reset asserted mid-sweep: immediate return to reset values; frame lost, not counted.

## Configuration
- NEURAL_PKT_DROP_CNT_EN defined: drop_count is a 16-bit saturating counter of dropped frames, sticks at 0xFFFF, cleared only by reset.
- Undefined: no counter; drop_count tied to 0. overrun pulse present in both builds.

## Test plan
- Reset, enable=1, ch_mask=0xFFFF, snap_data ch i = i*0x0100, pkt_ready=1 -> 16 packets, CH 0..15, DATA 0x0000..0x0F00, sof only on ch0, eof only on ch15, identical TS, first pkt_valid one cycle after strobe.
- ch_mask=0x8421, data all 0xAAAA -> 4 packets CH 0,5,10,15 on consecutive cycles; sof on CH0, eof on CH15.
- ch_mask=0x0040 -> single packet CH6 with [1:0]=2'b11; enable=0 strobe -> no packets, overrun=0, drop_count=0.
- pkt_ready toggled 1-cycle-on/2-off mid-frame -> pkt_data stable while stalled; all 16 packets in order, none duplicated.
- Second strobe 3 cycles into a 16-channel sweep -> overrun pulse once, drop_count=1 (0 without NEURAL_PKT_DROP_CNT_EN), first frame unaffected; 70000 forced drops -> drop_count=0xFFFF.
- Preload-free wrap: run 2^32-cycle-equivalent by forcing ts_cnt=0xFFFFFFFE, strobe at 0xFFFFFFFF then at 0x00000010 -> TS fields 0xFFFFFFFF and 0x00000010; sys_rst_n pulsed mid-sweep -> pkt_valid=0 immediately, snap_ready=1.
